adc_sample_packer: RTL

- Downstream of the readout sequencer.
- Captures the serial ADC result lanes during each transfer window and assembles them into BITS-wide samples tagged with row and lane.
- Buffers the samples in a small FIFO, then emits them as a framed 2-byte-per-sample stream with a valid/ready handshake toward the host link (UART/USB bridge).

---
 rtl/adc_sample_packer_if.sv | 10 +
 rtl/adc_sample_packer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adc_sample_packer_if.sv
// Byte stream from the sample packer toward the host link bridge.
// Valid/ready: a byte moves on a clk_out1 rising edge with ByteValid & ByteReady; while ByteValid & ~ByteReady the source holds ByteData and ByteValid.
interface adc_sample_packer_if;
   logic [7:0] ByteData;
   logic       ByteValid;
   logic       ByteReady;

   modport master (output ByteData, output ByteValid, input ByteReady);
   modport slave  (input ByteData, input ByteValid, output ByteReady);
endinterface

// File: rtl/adc_sample_packer.sv
// Captures the two serial ADC lanes per transfer window, queues {row, lane, data} entries
// and streams each entry as two framed bytes over a valid/ready link.
module adc_sample_packer #(
   parameter int BITS       = 10,
   parameter int SKIP       = 1,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_out1,
   input  logic                  Rst_n,
   input  logic                  BitClk,
   input  logic                  TrnsfrEn,
   input  logic                  SdIn0,
   input  logic                  SdIn1,
   input  logic [2:0]            RowSel,
   adc_sample_packer_if.master   byte_if,
   output logic                  Overflow,
   output logic                  ShortErr,
   output logic [7:0]            DropCnt,
   input  logic                  ClrErr,
   output logic [DEPTH_LOG2:0]   Level,
   output logic [1:0]            fsm_state
);

   localparam int SKW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
   localparam int PW  = DEPTH_LOG2;
   localparam int LW  = DEPTH_LOG2 + 1;
   localparam logic [3:0]     BITS_L  = 4'(BITS);
   localparam logic [SKW-1:0] SKIP_L  = SKW'(SKIP);
   localparam logic [LW-1:0]  DEPTH_L = LW'(2 ** DEPTH_LOG2);

   typedef enum logic [1:0] {IDLE = 2'd0, B0 = 2'd1, B1 = 2'd2} out_state_t;

   logic           bitclk_d, trnsfr_d;
   logic [2:0]     row_q;
   logic [9:0]     sh0, sh1;
   logic [3:0]     bitcnt;
   logic [SKW-1:0] skip_cnt;
   logic           push_pend;
   logic           qedge, win_start, short_evt;

   logic [13:0]    mem [2 ** DEPTH_LOG2];
   logic [PW-1:0]  wptr, rptr;
   logic [13:0]    entry0, entry1, head, next_head;
   logic           pop, wr0, wr1;
   logic [1:0]     ndrop;
   logic [LW-1:0]  free_slots, level_next;
   logic [8:0]     drop_sum;
   out_state_t     state;

   function automatic logic [7:0] first_byte(input logic [13:0] e);
      return {1'b1, e[10], e[13:11], e[9:7]};
   endfunction

   assign qedge     = BitClk & ~bitclk_d & TrnsfrEn;
   assign win_start = TrnsfrEn & ~trnsfr_d;
   // A window that closes mid-sample, or before the pipeline latency elapsed, is reported.
   assign short_evt = ~TrnsfrEn & trnsfr_d &
                      (((bitcnt != 4'd0) && (bitcnt < BITS_L)) || (skip_cnt != '0));

   always_ff @(posedge clk_out1 or negedge Rst_n) begin
      if (!Rst_n) begin
         bitclk_d  <= 1'b0;
         trnsfr_d  <= 1'b0;
         row_q     <= 3'd0;
         sh0       <= 10'd0;
         sh1       <= 10'd0;
         bitcnt    <= 4'd0;
         skip_cnt  <= '0;
         push_pend <= 1'b0;
      end else begin
         bitclk_d  <= BitClk;
         trnsfr_d  <= TrnsfrEn;
         push_pend <= 1'b0;
         if (win_start) begin
            row_q    <= RowSel;
            bitcnt   <= 4'd0;
            sh0      <= 10'd0;
            sh1      <= 10'd0;
            skip_cnt <= SKIP_L;
         end else if (qedge) begin
            if (skip_cnt != '0) begin
               skip_cnt <= skip_cnt - 1'b1;
            end else if (bitcnt < BITS_L) begin
               sh0       <= {sh0[8:0], SdIn0};
               sh1       <= {sh1[8:0], SdIn1};
               bitcnt    <= bitcnt + 4'd1;
               push_pend <= (bitcnt == BITS_L - 4'd1);
            end
         end
      end
   end

   assign entry0    = {row_q, 1'b0, sh0};
   assign entry1    = {row_q, 1'b1, sh1};
   assign head      = mem[rptr];
   assign next_head = mem[rptr + 1'b1];
   assign pop       = (state == B1) & byte_if.ByteReady;

   // Free space counts the slot released by a same-cycle pop; lane 1 is dropped first.
   always_comb begin
      free_slots = DEPTH_L - Level + LW'(pop);
      wr0        = push_pend && (free_slots != '0);
      wr1        = push_pend && (free_slots >= LW'(2));
      ndrop      = 2'(push_pend & ~wr0) + 2'(push_pend & ~wr1);
      level_next = Level - LW'(pop) + LW'(wr0) + LW'(wr1);
      drop_sum   = {1'b0, (ClrErr ? 8'd0 : DropCnt)} + 9'(ndrop);
   end

   always_ff @(posedge clk_out1) begin
      if (wr0) mem[wptr] <= entry0;
      if (wr1) mem[wptr + 1'b1] <= entry1;
   end

   always_ff @(posedge clk_out1 or negedge Rst_n) begin
      if (!Rst_n) begin
         wptr              <= '0;
         rptr              <= '0;
         Level             <= '0;
         state             <= IDLE;
         byte_if.ByteData  <= 8'd0;
         byte_if.ByteValid <= 1'b0;
         Overflow          <= 1'b0;
         ShortErr          <= 1'b0;
         DropCnt           <= 8'd0;
      end else begin
         wptr  <= wptr + PW'(wr0) + PW'(wr1);
         rptr  <= rptr + PW'(pop);
         Level <= level_next;

         case (state)
            IDLE: if (Level != '0) begin
               byte_if.ByteData  <= first_byte(head);
               byte_if.ByteValid <= 1'b1;
               state             <= B0;
            end
            B0: if (byte_if.ByteReady) begin
               byte_if.ByteData <= {1'b0, head[6:0]};
               state            <= B1;
            end
            B1: if (byte_if.ByteReady) begin
               // Only entries already in memory can follow back-to-back.
               if (Level > LW'(1)) begin
                  byte_if.ByteData <= first_byte(next_head);
                  state            <= B0;
               end else begin
                  byte_if.ByteValid <= 1'b0;
                  state             <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (ndrop != 2'd0) begin
            Overflow <= 1'b1;
            DropCnt  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         end else if (ClrErr) begin
            Overflow <= 1'b0;
            DropCnt  <= 8'd0;
         end

         if (short_evt)   ShortErr <= 1'b1;
         else if (ClrErr) ShortErr <= 1'b0;
      end
   end

   assign fsm_state = state;

endmodule
